// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multicycle controller.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zf;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_sel;
    logic       pc_we;
    logic [3:0] state;

    modport master (
        input  op, funct, zf,
        output ir_we, mem_we, reg_we, i_or_d, mem_to_reg, reg_dst, alu_src_a,
               alu_src_b, pc_src, alu_sel, pc_we, state
    );

    modport slave (
        output op, funct, zf,
        input  ir_we, mem_we, reg_we, i_or_d, mem_to_reg, reg_dst, alu_src_a,
               alu_src_b, pc_src, alu_sel, pc_we, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: only the state is registered, all strobes
// decode from it. Define MULTICYCLE_CTRL_JUMP_EN to add the j instruction.
module multicycle_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_ctrl_if.master      bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10
`ifdef MULTICYCLE_CTRL_JUMP_EN
        , S_JUMP = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MULTICYCLE_CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOP = 3'b011;

    state_t     r_state;
    state_t     w_next;
    logic       w_ir_we, w_mem_we, w_reg_we, w_i_or_d, w_mem_to_reg, w_reg_dst;
    logic       w_alu_src_a, w_pc_we;
    logic [1:0] w_alu_src_b, w_pc_src;
    logic [2:0] w_alu_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = S_FETCH;
        w_ir_we      = 1'b0;
        w_mem_we     = 1'b0;
        w_reg_we     = 1'b0;
        w_i_or_d     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_alu_sel    = ALU_NOP;
        w_pc_we      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_we     = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu_sel   = ALU_ADD;
                w_pc_we     = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                // ALU speculatively forms the branch target while op is decoded
                w_alu_src_b = 2'b11;
                w_alu_sel   = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_ADDI:      w_next = S_ADDIEX;
`ifdef MULTICYCLE_CTRL_JUMP_EN
                    OP_J:         w_next = S_JUMP;
`endif
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_sel   = ALU_ADD;
                w_next      = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_i_or_d = 1'b1;
                w_next   = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_we     = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_i_or_d = 1'b1;
                w_mem_we = 1'b1;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                case (bus.funct)
                    6'b100100: w_alu_sel = ALU_AND;
                    6'b100101: w_alu_sel = ALU_OR;
                    6'b100000: w_alu_sel = ALU_ADD;
                    6'b100010: w_alu_sel = ALU_SUB;
                    6'b101010: w_alu_sel = ALU_SLT;
                    default:   w_alu_sel = ALU_NOP;
                endcase
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_we  = 1'b1;
                w_reg_dst = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a = 1'b1;
                w_alu_sel   = ALU_SUB;
                w_pc_src    = 2'b01;
                w_pc_we     = bus.zf;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_sel   = ALU_ADD;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_we = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP: begin
                w_pc_src = 2'b10;
                w_pc_we  = 1'b1;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    assign bus.ir_we      = w_ir_we;
    assign bus.mem_we     = w_mem_we;
    assign bus.reg_we     = w_reg_we;
    assign bus.i_or_d     = w_i_or_d;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_sel    = w_alu_sel;
    assign bus.pc_we      = w_pc_we;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams checked against a per-instruction sequence/strobe model.
module tb_multicycle_ctrl;
    logic clk;
    logic rst;
    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_we;
        logic       mem_we;
        logic       reg_we;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_sel;
        logic       pc_we;
    } outs_t;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    cap_st[$];
    outs_t cap_o[$];
    int    exp_q[$];

    function automatic outs_t cur_outs();
        outs_t o;
        o.ir_we = bus.ir_we;           o.mem_we = bus.mem_we;
        o.reg_we = bus.reg_we;         o.i_or_d = bus.i_or_d;
        o.mem_to_reg = bus.mem_to_reg; o.reg_dst = bus.reg_dst;
        o.alu_src_a = bus.alu_src_a;   o.alu_src_b = bus.alu_src_b;
        o.pc_src = bus.pc_src;         o.alu_sel = bus.alu_sel;
        o.pc_we = bus.pc_we;
        return o;
    endfunction

    // Reference: the state walk each opcode takes, FETCH to FETCH.
    function automatic void build_seq(logic [5:0] op);
        exp_q.delete();
        case (op)
            6'b100011: exp_q = '{0, 1, 2, 3, 4, 0};
            6'b101011: exp_q = '{0, 1, 2, 5, 0};
            6'b000000: exp_q = '{0, 1, 6, 7, 0};
            6'b000100: exp_q = '{0, 1, 8, 0};
            6'b001000: exp_q = '{0, 1, 9, 10, 0};
`ifdef MULTICYCLE_CTRL_JUMP_EN
            6'b000010: exp_q = '{0, 1, 11, 0};
`endif
            default:   exp_q = '{0, 1, 0};
        endcase
    endfunction

    function automatic logic [2:0] funct_op(logic [5:0] fn);
        logic [5:0] codes [5] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
        logic [2:0] ops   [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        for (int i = 0; i < 5; i++) if (fn == codes[i]) return ops[i];
        return 3'b011;
    endfunction

    function automatic outs_t exp_out(int st, logic [5:0] fn, logic z);
        outs_t o;
        o = '0;
        o.alu_sel = 3'b011;
        case (st)
            0:  begin o.ir_we = 1; o.alu_src_b = 2'b01; o.alu_sel = 3'b010; o.pc_we = 1; end
            1:  begin o.alu_src_b = 2'b11; o.alu_sel = 3'b010; end
            2, 9: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_sel = 3'b010; end
            3:  o.i_or_d = 1;
            4:  begin o.reg_we = 1; o.mem_to_reg = 1; end
            5:  begin o.i_or_d = 1; o.mem_we = 1; end
            6:  begin o.alu_src_a = 1; o.alu_sel = funct_op(fn); end
            7:  begin o.reg_we = 1; o.reg_dst = 1; end
            8:  begin o.alu_src_a = 1; o.alu_sel = 3'b110; o.pc_src = 2'b01; o.pc_we = z; end
            10: o.reg_we = 1;
            11: begin o.pc_src = 2'b10; o.pc_we = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // Runs one instruction from FETCH, recording state/outputs each cycle
    // until FETCH comes back (bounded).
    task automatic capture(input logic [5:0] o, input logic [5:0] f, input logic z);
        bus.op = o; bus.funct = f; bus.zf = z;
        cap_st.delete();
        cap_o.delete();
        for (int c = 0; c < 10; c++) begin
            #1;
            cap_st.push_back(int'(bus.state));
            cap_o.push_back(cur_outs());
            if (c > 0 && bus.state == 4'd0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        outs_t o;
        rst = 1'b1; bus.op = 6'b111111; bus.funct = '0; bus.zf = 1'b0;
        #3;
        o = cur_outs();
        n_chk++;
        if (bus.state !== 4'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state); end
        n_chk++;
        if (o !== exp_out(0, '0, 1'b0)) begin n_fail++; $display("FAIL reset_outs got %h want %h", o, exp_out(0, '0, 1'b0)); end
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (bus.state !== 4'd0) begin n_fail++; $display("FAIL reset_hold got %0d want 0", bus.state); end
        rst = 1'b0;
    endtask

    task automatic test_lw();
        capture(6'b100011, 6'b0, 1'b0);
        build_seq(6'b100011);
        n_chk++;
        if (cap_st.size() != exp_q.size()) begin n_fail++; $display("FAIL lw_len got %0d want %0d", cap_st.size(), exp_q.size()); end
        for (int i = 0; i < cap_st.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (cap_st[i] !== exp_q[i]) begin n_fail++; $display("FAIL lw_state[%0d] got %0d want %0d", i, cap_st[i], exp_q[i]); end
            n_chk++;
            if (cap_o[i].reg_we !== (cap_st[i] == 4) || cap_o[i].mem_to_reg !== (cap_st[i] == 4)) begin
                n_fail++; $display("FAIL lw_wb[%0d] got reg_we=%b mem_to_reg=%b in state %0d", i, cap_o[i].reg_we, cap_o[i].mem_to_reg, cap_st[i]);
            end
            n_chk++;
            if (cap_o[i] !== exp_out(exp_q[i], '0, 1'b0)) begin n_fail++; $display("FAIL lw_outs[%0d] got %h want %h", i, cap_o[i], exp_out(exp_q[i], '0, 1'b0)); end
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b111111};
        logic [2:0] sel [6] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011};
        for (int k = 0; k < 6; k++) begin
            capture(6'b000000, fns[k], 1'b0);
            n_chk++;
            if (cap_st.size() != 5 || cap_st[2] !== 6) begin
                n_fail++; $display("FAIL rtype_seq funct=%b got len %0d", fns[k], cap_st.size());
            end else begin
                n_chk++;
                if (cap_o[2].alu_sel !== sel[k]) begin n_fail++; $display("FAIL rtype_alu_sel funct=%b got %b want %b", fns[k], cap_o[2].alu_sel, sel[k]); end
                n_chk++;
                if (cap_st[3] !== 7 || cap_o[3].reg_dst !== 1'b1 || cap_st[4] !== 0) begin
                    n_fail++; $display("FAIL rtype_wb got state %0d reg_dst %b", cap_st[3], cap_o[3].reg_dst);
                end
            end
        end
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            logic z;
            z = (k == 0);
            capture(6'b000100, 6'b0, z);
            n_chk++;
            if (cap_st.size() != 4 || cap_st[2] !== 8 || cap_st[3] !== 0) begin
                n_fail++; $display("FAIL beq_seq zf=%b got len %0d", z, cap_st.size());
            end else begin
                n_chk++;
                if (cap_o[2].pc_we !== z || cap_o[2].pc_src !== 2'b01) begin
                    n_fail++; $display("FAIL beq_pc zf=%b got pc_we=%b pc_src=%b want %b/01", z, cap_o[2].pc_we, cap_o[2].pc_src, z);
                end
            end
        end
    endtask

    task automatic test_sw_addi();
        logic [5:0] ops [2] = '{6'b101011, 6'b001000};
        for (int k = 0; k < 2; k++) begin
            capture(ops[k], 6'b0, 1'b0);
            n_chk++;
            if (cap_st.size() - 1 != 4) begin n_fail++; $display("FAIL lat_op%b got %0d want 4", ops[k], cap_st.size() - 1); end
            for (int i = 0; i < cap_st.size(); i++) begin
                n_chk++;
                if (cap_o[i].mem_we !== (cap_st[i] == 5) || cap_o[i].reg_we !== (cap_st[i] == 10)) begin
                    n_fail++; $display("FAIL we_op%b[%0d] got mem_we=%b reg_we=%b in state %0d", ops[k], i, cap_o[i].mem_we, cap_o[i].reg_we, cap_st[i]);
                end
            end
        end
    endtask

    task automatic test_jump();
        capture(6'b000010, 6'b0, 1'b0);
`ifdef MULTICYCLE_CTRL_JUMP_EN
        n_chk++;
        if (cap_st.size() != 4 || cap_st[2] !== 11 || cap_st[3] !== 0 || cap_o[2].pc_src !== 2'b10 || cap_o[2].pc_we !== 1'b1) begin
            n_fail++; $display("FAIL jump_en got len %0d", cap_st.size());
        end
`else
        n_chk++;
        if (cap_st.size() != 3 || cap_st[1] !== 1 || cap_st[2] !== 0 || cap_o[1].pc_we !== 1'b0) begin
            n_fail++; $display("FAIL jump_dis got len %0d", cap_st.size());
        end
`endif
    endtask

    task automatic test_async_reset();
        bus.op = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (bus.state !== 4'd3) begin n_fail++; $display("FAIL arst_pre got %0d want 3", bus.state); end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (bus.state !== 4'd0 || bus.ir_we !== 1'b1 || bus.pc_we !== 1'b1) begin
            n_fail++; $display("FAIL arst_async got state %0d ir_we %b", bus.state, bus.ir_we);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        capture(6'b100011, 6'b0, 1'b0);
        n_chk++;
        if (cap_st.size() != 6 || cap_st[1] !== 1 || cap_st[3] !== 3 || cap_st[5] !== 0) begin
            n_fail++; $display("FAIL arst_restart got len %0d", cap_st.size());
        end
    endtask

    task automatic test_random();
        logic [5:0] opl [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b000001};
        logic [5:0] fnl [6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b000000};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] o, f;
            logic z;
            o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : opl[$urandom_range(0, 7)];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fnl[$urandom_range(0, 5)];
            z = 1'($urandom);
            capture(o, f, z);
            build_seq(o);
            n_chk++;
            if (cap_st.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_len op=%b got %0d want %0d", o, cap_st.size(), exp_q.size()); end
            for (int i = 0; i < cap_st.size() && i < exp_q.size(); i++) begin
                n_chk++;
                if (cap_st[i] !== exp_q[i] || cap_o[i] !== exp_out(exp_q[i], f, z)) begin
                    n_fail++; $display("FAIL rnd op=%b f=%b z=%b [%0d] got st %0d outs %h want st %0d outs %h",
                                       o, f, z, i, cap_st[i], cap_o[i], exp_q[i], exp_out(exp_q[i], f, z));
                end
`ifndef MULTICYCLE_CTRL_JUMP_EN
                n_chk++;
                if (cap_o[i].pc_src === 2'b10) begin n_fail++; $display("FAIL rnd_pc_src op=%b got 10 want not 10", o); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_addi();
        test_jump();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
